ex_stage_ex_mem: RTL and testbench

Execute stage of the 5-stage pipeline. It consumes the ID/EX register bundle and performs operand forwarding selection, ALU control decode, the ALU operation, branch-target add and destination-register select. Results are captured into the EX/MEM pipeline register. Stall (hold) and flush (bubble) controls come from the hazard unit; the EX/MEM result is fed back internally as a forwarding source.

---
 rtl/ex_stage_ex_mem_if.sv | 57 +++++
 rtl/ex_stage_ex_mem.sv | 126 ++++++++++++
 tb/tb_ex_stage_ex_mem.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_ex_mem_if.sv
// ID/EX bundle in, EX/MEM register out, plus hazard-unit and forwarding controls.
interface ex_stage_ex_mem_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
);
   // ID/EX controls
   logic              i_MemtoReg;
   logic              i_MemWrite;
   logic              i_MemRead;
   logic              i_Branch;
   logic              i_ALUSrc;
   logic              i_RegDst;
   logic              i_RegWrite;
   logic [1:0]        i_ALUOP;
   // ID/EX data
   logic [DATA_W-1:0] i_PCplus4;
   logic [DATA_W-1:0] i_Rdata1;
   logic [DATA_W-1:0] i_Rdata2;
   logic [DATA_W-1:0] i_signextImmediate;
   logic [REG_AW-1:0] i_RegDst1;
   logic [REG_AW-1:0] i_RegDst2;
   // forwarding and hazard controls
   logic [1:0]        i_ForwardA;
   logic [1:0]        i_ForwardB;
   logic [DATA_W-1:0] i_WBdata;
   logic              i_stall;
   logic              i_flush;
   // EX/MEM register
   logic              o_MemtoReg;
   logic              o_MemWrite;
   logic              o_MemRead;
   logic              o_Branch;
   logic              o_RegWrite;
   logic              o_Zero;
   logic [DATA_W-1:0] o_ALUResult;
   logic [DATA_W-1:0] o_BranchTarget;
   logic [DATA_W-1:0] o_WriteData;
   logic [REG_AW-1:0] o_WriteReg;

   modport slave (
      input  i_MemtoReg, i_MemWrite, i_MemRead, i_Branch, i_ALUSrc, i_RegDst,
             i_RegWrite, i_ALUOP, i_PCplus4, i_Rdata1, i_Rdata2,
             i_signextImmediate, i_RegDst1, i_RegDst2, i_ForwardA, i_ForwardB,
             i_WBdata, i_stall, i_flush,
      output o_MemtoReg, o_MemWrite, o_MemRead, o_Branch, o_RegWrite, o_Zero,
             o_ALUResult, o_BranchTarget, o_WriteData, o_WriteReg
   );

   modport master (
      output i_MemtoReg, i_MemWrite, i_MemRead, i_Branch, i_ALUSrc, i_RegDst,
             i_RegWrite, i_ALUOP, i_PCplus4, i_Rdata1, i_Rdata2,
             i_signextImmediate, i_RegDst1, i_RegDst2, i_ForwardA, i_ForwardB,
             i_WBdata, i_stall, i_flush,
      input  o_MemtoReg, o_MemWrite, o_MemRead, o_Branch, o_RegWrite, o_Zero,
             o_ALUResult, o_BranchTarget, o_WriteData, o_WriteReg
   );
endinterface

// File: rtl/ex_stage_ex_mem.sv
// Execute stage: forwarding, ALU control/ALU, branch target, dest select, EX/MEM register.
module ex_stage_ex_mem #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input logic             i_clk,
   input logic             i_rstn,
   ex_stage_ex_mem_if.slave bus
);
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned FUNCT_W = 6;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
   } alu_op_e;

   logic [DATA_W-1:0]  op_a;
   logic [DATA_W-1:0]  b_fwd;
   logic [DATA_W-1:0]  op_b;
   logic [DATA_W-1:0]  alu_res;
   logic [DATA_W-1:0]  br_tgt;
   logic [REG_AW-1:0]  wr_reg;
   logic [FUNCT_W-1:0] funct;
   logic [SHAMT_W-1:0] shamt;
   alu_op_e            alu_op;

   // EX/MEM register contents
   logic              q_memtoreg, q_memwrite, q_memread, q_branch, q_regwrite, q_zero;
   logic [DATA_W-1:0] q_alu_res, q_br_tgt, q_wr_data;
   logic [REG_AW-1:0] q_wr_reg;

   assign funct = bus.i_signextImmediate[FUNCT_W-1:0];
   assign shamt = bus.i_signextImmediate[FUNCT_W+SHAMT_W-1:FUNCT_W];

   // Operand forwarding; code 10 takes the pre-edge EX/MEM result
   always_comb begin
      op_a = bus.i_Rdata1;
      case (bus.i_ForwardA)
         2'b10:   op_a = q_alu_res;
         2'b01:   op_a = bus.i_WBdata;
         default: op_a = bus.i_Rdata1;
      endcase
      b_fwd = bus.i_Rdata2;
      case (bus.i_ForwardB)
         2'b10:   b_fwd = q_alu_res;
         2'b01:   b_fwd = bus.i_WBdata;
         default: b_fwd = bus.i_Rdata2;
      endcase
      op_b = bus.i_ALUSrc ? bus.i_signextImmediate : b_fwd;
   end

   // ALU control decode from op class and funct
   always_comb begin
      alu_op = ALU_ADD;
      case (bus.i_ALUOP)
         2'b01: alu_op = ALU_SUB;
         2'b10: begin
            case (funct)
               6'b100000: alu_op = ALU_ADD;
               6'b100010: alu_op = ALU_SUB;
               6'b100100: alu_op = ALU_AND;
               6'b100101: alu_op = ALU_OR;
               6'b101010: alu_op = ALU_SLT;
               6'b000000: alu_op = ALU_SLL;
               6'b000010: alu_op = ALU_SRL;
               default:   alu_op = ALU_ADD;
            endcase
         end
         default: alu_op = ALU_ADD;
      endcase
   end

   // ALU, branch target and destination register
   always_comb begin
      alu_res = op_a + op_b;
      case (alu_op)
         ALU_SUB: alu_res = op_a - op_b;
         ALU_AND: alu_res = op_a & op_b;
         ALU_OR:  alu_res = op_a | op_b;
         ALU_SLT: alu_res = DATA_W'($signed(op_a) < $signed(op_b));
         ALU_SLL: alu_res = op_b << shamt;
         ALU_SRL: alu_res = op_b >> shamt;
         default: alu_res = op_a + op_b;
      endcase
      br_tgt = bus.i_PCplus4 + {bus.i_signextImmediate[DATA_W-3:0], 2'b00};
      wr_reg = bus.i_RegDst ? bus.i_RegDst2 : bus.i_RegDst1;
   end

   // EX/MEM register: flush clears controls only, stall holds everything
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         q_memtoreg <= 1'b0;
         q_memwrite <= 1'b0;
         q_memread  <= 1'b0;
         q_branch   <= 1'b0;
         q_regwrite <= 1'b0;
         q_zero     <= 1'b0;
         q_alu_res  <= '0;
         q_br_tgt   <= '0;
         q_wr_data  <= '0;
         q_wr_reg   <= '0;
      end else if (bus.i_flush || !bus.i_stall) begin
         q_memtoreg <= bus.i_MemtoReg & ~bus.i_flush;
         q_memwrite <= bus.i_MemWrite & ~bus.i_flush;
         q_memread  <= bus.i_MemRead  & ~bus.i_flush;
         q_branch   <= bus.i_Branch   & ~bus.i_flush;
         q_regwrite <= bus.i_RegWrite & ~bus.i_flush;
         q_zero     <= (alu_res == '0);
         q_alu_res  <= alu_res;
         q_br_tgt   <= br_tgt;
         q_wr_data  <= b_fwd;
         q_wr_reg   <= wr_reg;
      end
   end

   assign bus.o_MemtoReg     = q_memtoreg;
   assign bus.o_MemWrite     = q_memwrite;
   assign bus.o_MemRead      = q_memread;
   assign bus.o_Branch       = q_branch;
   assign bus.o_RegWrite     = q_regwrite;
   assign bus.o_Zero         = q_zero;
   assign bus.o_ALUResult    = q_alu_res;
   assign bus.o_BranchTarget = q_br_tgt;
   assign bus.o_WriteData    = q_wr_data;
   assign bus.o_WriteReg     = q_wr_reg;
endmodule

// File: tb/tb_ex_stage_ex_mem.sv
// Bench for ex_stage_ex_mem: cycle model + per-cycle compare + directed literal checks.
module tb_ex_stage_ex_mem;
   logic i_clk;
   logic i_rstn;
   int   n_pass;
   int   n_total;

   ex_stage_ex_mem_if #(.DATA_W(32), .REG_AW(5)) bus ();

   ex_stage_ex_mem dut (.i_clk(i_clk), .i_rstn(i_rstn), .bus(bus));

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // model state: what the EX/MEM register must hold
   logic [4:0]  m_ctrl;   // {MemtoReg, MemWrite, MemRead, Branch, RegWrite}
   logic        m_zero;
   logic [31:0] m_res, m_tgt, m_wd;
   logic [4:0]  m_wr;

   function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] rd,
                                        input logic [31:0] prev, input logic [31:0] wb);
      if (f == 2'b10) return prev;
      if (f == 2'b01) return wb;
      return rd;
   endfunction

   function automatic logic [31:0] ex(input logic [1:0] op, input logic [31:0] imm,
                                      input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(imm[10:6]);
      if (op == 2'b01) return a - b;
      if (op != 2'b10) return a + b;
      case (imm[5:0])
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'h00:   return b << sh;
         6'h02:   return b >> sh;
         default: return a + b;
      endcase
   endfunction

   // model update on each edge, reset at once
   always @(posedge i_clk or negedge i_rstn) begin
      logic [31:0] a, bf, b, r;
      if (!i_rstn) begin
         m_ctrl = '0; m_zero = 1'b0; m_res = '0; m_tgt = '0; m_wd = '0; m_wr = '0;
      end else if (bus.i_flush || !bus.i_stall) begin
         a  = pick(bus.i_ForwardA, bus.i_Rdata1, m_res, bus.i_WBdata);
         bf = pick(bus.i_ForwardB, bus.i_Rdata2, m_res, bus.i_WBdata);
         b  = bus.i_ALUSrc ? bus.i_signextImmediate : bf;
         r  = ex(bus.i_ALUOP, bus.i_signextImmediate, a, b);
         m_ctrl = bus.i_flush ? 5'b0 : {bus.i_MemtoReg, bus.i_MemWrite, bus.i_MemRead,
                                       bus.i_Branch, bus.i_RegWrite};
         m_zero = (r == 32'd0);
         m_res  = r;
         m_tgt  = bus.i_PCplus4 + (bus.i_signextImmediate * 32'd4);
         m_wd   = bf;
         m_wr   = bus.i_RegDst ? bus.i_RegDst2 : bus.i_RegDst1;
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // compare every cycle on the falling edge
   always @(negedge i_clk) begin
      chk("cycle",
          {5'b0, bus.o_MemtoReg, bus.o_MemWrite, bus.o_MemRead, bus.o_Branch, bus.o_RegWrite,
           bus.o_Zero, bus.o_ALUResult, bus.o_BranchTarget, bus.o_WriteData, bus.o_WriteReg},
          {5'b0, m_ctrl, m_zero, m_res, m_tgt, m_wd, m_wr});
   end

   function automatic logic [4:0] ctrl_out();
      return {bus.o_MemtoReg, bus.o_MemWrite, bus.o_MemRead, bus.o_Branch, bus.o_RegWrite};
   endfunction

   task automatic clear();
      bus.i_MemtoReg = 0; bus.i_MemWrite = 0; bus.i_MemRead = 0; bus.i_Branch = 0;
      bus.i_ALUSrc = 0; bus.i_RegDst = 0; bus.i_RegWrite = 0; bus.i_ALUOP = 2'b00;
      bus.i_PCplus4 = 0; bus.i_Rdata1 = 0; bus.i_Rdata2 = 0; bus.i_signextImmediate = 0;
      bus.i_RegDst1 = 0; bus.i_RegDst2 = 0; bus.i_ForwardA = 0; bus.i_ForwardB = 0;
      bus.i_WBdata = 0; bus.i_stall = 0; bus.i_flush = 0;
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic rtype(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
      bus.i_ALUOP = 2'b10; bus.i_ALUSrc = 0; bus.i_Rdata1 = a; bus.i_Rdata2 = b;
      bus.i_signextImmediate = imm;
      step();
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      clear();
      // 1. reset with busy inputs
      i_rstn = 0;
      bus.i_RegWrite = 1; bus.i_MemRead = 1; bus.i_Rdata1 = 32'h1234; bus.i_PCplus4 = 32'h40;
      step(); step();
      chk("rst_res", bus.o_ALUResult, 0);
      chk("rst_ctrl", ctrl_out(), 0);
      chk("rst_tgt", bus.o_BranchTarget, 0);
      i_rstn = 1;
      clear();
      bus.i_Rdata1 = 32'h10; bus.i_signextImmediate = 32'h4; bus.i_ALUSrc = 1;
      step();
      chk("first_add", bus.o_ALUResult, 32'h14);
      chk("first_zero", bus.o_Zero, 0);

      // 2. R-type sweep
      rtype(32'hF, 32'hFFFFFFF0, 32'h20); chk("r_add", bus.o_ALUResult, 32'hFFFFFFFF);
      rtype(32'hF, 32'hFFFFFFF0, 32'h22); chk("r_sub", bus.o_ALUResult, 32'h1F);
      rtype(32'hF, 32'hFFFFFFF0, 32'h24); chk("r_and", bus.o_ALUResult, 32'h0);
      chk("r_and_zero", bus.o_Zero, 1);
      rtype(32'hF, 32'hFFFFFFF0, 32'h25); chk("r_or", bus.o_ALUResult, 32'hFFFFFFFF);
      rtype(32'hF, 32'hFFFFFFF0, 32'h2A); chk("r_slt0", bus.o_ALUResult, 32'h0);
      rtype(32'hFFFFFFF0, 32'hF, 32'h2A); chk("r_slt1", bus.o_ALUResult, 32'h1);
      rtype(32'h0, 32'h1, 32'h100);       chk("r_sll", bus.o_ALUResult, 32'h10);
      rtype(32'h0, 32'h80000000, 32'h102); chk("r_srl", bus.o_ALUResult, 32'h08000000);
      rtype(32'hF, 32'hFFFFFFF0, 32'h3F); chk("r_unk", bus.o_ALUResult, 32'hFFFFFFFF);

      // 3. beq path and target wrap
      clear();
      bus.i_ALUOP = 2'b01; bus.i_Branch = 1; bus.i_Rdata1 = 32'h1234; bus.i_Rdata2 = 32'h1234;
      bus.i_PCplus4 = 32'h100; bus.i_signextImmediate = 32'hFFFFFFFE;
      step();
      chk("beq_zero", bus.o_Zero, 1);
      chk("beq_tgt", bus.o_BranchTarget, 32'hF8);
      chk("beq_br", bus.o_Branch, 1);
      bus.i_PCplus4 = 32'hFFFFFFFC; bus.i_signextImmediate = 32'h1;
      step();
      chk("tgt_wrap", bus.o_BranchTarget, 32'h0);

      // 4. forwarding
      clear();
      bus.i_Rdata1 = 32'hAA; bus.i_ALUSrc = 1;
      step();
      chk("fwd_seed", bus.o_ALUResult, 32'hAA);
      bus.i_ALUSrc = 0; bus.i_ForwardA = 2'b10; bus.i_ForwardB = 2'b01; bus.i_WBdata = 32'h55;
      bus.i_Rdata1 = 32'h1; bus.i_Rdata2 = 32'h2;
      rtype(32'h1, 32'h2, 32'h20);
      chk("fwd_res", bus.o_ALUResult, 32'hFF);
      chk("fwd_wd", bus.o_WriteData, 32'h55);
      bus.i_ForwardA = 2'b11; bus.i_ForwardB = 2'b00;
      rtype(32'h7, 32'h3, 32'h20);
      chk("fwd11", bus.o_ALUResult, 32'hA);

      // 5. stall holds, flush wins over stall
      bus.i_stall = 1; bus.i_RegWrite = 1; bus.i_ForwardA = 2'b10;
      for (int i = 0; i < 3; i++) begin
         bus.i_Rdata2 = 32'h100 + 32'(i); bus.i_PCplus4 = 32'h40 * 32'(i + 1);
         step();
         chk("stall_res", bus.o_ALUResult, 32'hA);
         chk("stall_wd", bus.o_WriteData, 32'h3);
         chk("stall_rw", bus.o_RegWrite, 0);
      end
      bus.i_flush = 1; bus.i_MemRead = 1; bus.i_ForwardA = 2'b00;
      rtype(32'h5, 32'h6, 32'h20);
      chk("sf_ctrl", ctrl_out(), 0);
      chk("sf_res", bus.o_ALUResult, 32'hB);
      clear();
      bus.i_flush = 1; bus.i_MemWrite = 1; bus.i_ALUSrc = 1; bus.i_Rdata1 = 32'h20;
      bus.i_signextImmediate = 32'h4;
      step();
      chk("flush_sw", bus.o_MemWrite, 0);
      chk("flush_sw_res", bus.o_ALUResult, 32'h24);

      // 6. destination select and store data
      clear();
      bus.i_RegDst1 = 5'd5; bus.i_RegDst2 = 5'd9;
      step();
      chk("rd_rt", bus.o_WriteReg, 5'd5);
      bus.i_RegDst = 1;
      step();
      chk("rd_rd", bus.o_WriteReg, 5'd9);
      clear();
      bus.i_MemWrite = 1; bus.i_ALUSrc = 1; bus.i_ForwardB = 2'b01; bus.i_WBdata = 32'hDEAD;
      bus.i_Rdata1 = 32'h100; bus.i_Rdata2 = 32'h1111; bus.i_signextImmediate = 32'h8;
      step();
      chk("sw_wd", bus.o_WriteData, 32'hDEAD);
      chk("sw_addr", bus.o_ALUResult, 32'h108);
      chk("sw_mw", bus.o_MemWrite, 1);

      // reset mid-operation clears at once
      #2 i_rstn = 0;
      #1;
      chk("async_rst", {bus.o_MemWrite, bus.o_ALUResult}, 0);
      step();
      i_rstn = 1;
      clear();
      step(); step();
      @(negedge i_clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
